// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the D-stage hazard scoreboard: forwarding encodings
// and default pipeline/datapath widths.
package hazard_scoreboard_pkg;

  localparam int unsigned DEF_NSTAGE = 3;
  localparam int unsigned DEF_NRD    = 2;
  localparam int unsigned DEF_AW     = 5;
  localparam int unsigned DEF_TW     = 2;
  localparam int unsigned DEF_SW     = 2;
  localparam int unsigned DEF_CW     = 32;

  // Forwarding source seen from D: GRF or the stage index holding the result
  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/hazard_port_match.sv
// Youngest-producer match for one D-stage read port: yields the port stall
// request and the forwarding select from the tracked stage contents.
module hazard_port_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = DEF_NSTAGE,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned TW     = DEF_TW,
  parameter int unsigned SW     = DEF_SW
) (
  input  logic [AW-1:0]        rs,
  input  logic [TW-1:0]        tuse,
  input  logic [NSTAGE*AW-1:0] stage_a3,
  input  logic [NSTAGE*TW-1:0] stage_tnew,
  output logic                 p_stall_c,
  output logic [SW-1:0]        sel_c
);

  logic          hit;
  logic [TW-1:0] win_tnew;
  logic [SW-1:0] win_idx;

  // Scan from the youngest stage; the first hit shadows any older producer
  always_comb begin
    hit      = 1'b0;
    win_tnew = '0;
    win_idx  = SW'(FWD_GRF);
    for (int k = 0; k < int'(NSTAGE); k++) begin
      if (!hit && (rs != '0) && (stage_a3[k*AW +: AW] == rs)) begin
        hit      = 1'b1;
        win_tnew = stage_tnew[k*TW +: TW];
        win_idx  = SW'(k + 1);
      end
    end
    p_stall_c = hit && (win_tnew > tuse);
    sel_c     = (hit && (win_tnew == '0)) ? win_idx : SW'(FWD_GRF);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard beside the D stage: tracks in-flight
// destinations, drives stall/forward selects and counts stalled cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NSTAGE = DEF_NSTAGE,
  parameter int unsigned NRD    = DEF_NRD,
  parameter int unsigned AW     = DEF_AW,
  parameter int unsigned TW     = DEF_TW,
  parameter int unsigned SW     = DEF_SW,
  parameter int unsigned CW     = DEF_CW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [AW-1:0]     d_a3,
  input  logic [TW-1:0]     d_tnew,
  input  logic [NRD*AW-1:0] d_rs,
  input  logic [NRD*TW-1:0] d_tuse,
  input  logic              d_mdu_use,
  input  logic              e_mdu_start,
  input  logic              mdu_busy,
  input  logic              flush,
  output logic              stall,
  output logic [NRD*SW-1:0] fwd_sel,
  output logic [CW-1:0]     stall_cnt
);

  logic [AW-1:0]        a3_q   [NSTAGE];
  logic [TW-1:0]        tnew_q [NSTAGE];
  logic [NSTAGE*AW-1:0] a3_flat;
  logic [NSTAGE*TW-1:0] tnew_flat;
  logic [NRD-1:0]       p_stall;
  logic                 mdu_stall;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  for (genvar k = 0; k < NSTAGE; k++) begin : g_flat
    assign a3_flat[k*AW +: AW]   = a3_q[k];
    assign tnew_flat[k*TW +: TW] = tnew_q[k];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_port
    hazard_port_match #(
      .NSTAGE (NSTAGE),
      .AW     (AW),
      .TW     (TW),
      .SW     (SW)
    ) u_match (
      .rs         (d_rs[i*AW +: AW]),
      .tuse       (d_tuse[i*TW +: TW]),
      .stage_a3   (a3_flat),
      .stage_tnew (tnew_flat),
      .p_stall_c  (p_stall[i]),
      .sel_c      (fwd_sel[i*SW +: SW])
    );
  end

  assign mdu_stall = d_valid && d_mdu_use && (mdu_busy || e_mdu_start);
  assign stall     = d_valid && ((|p_stall) || mdu_stall);

  // Stage shift with Tnew aging; a stalled D injects a bubble into E
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < int'(NSTAGE); k++) begin
        a3_q[k]   <= '0;
        tnew_q[k] <= '0;
      end
      stall_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
      if (flush) begin
        for (int k = 0; k < int'(NSTAGE); k++) begin
          a3_q[k]   <= '0;
          tnew_q[k] <= '0;
        end
      end else begin
        for (int k = 1; k < int'(NSTAGE); k++) begin
          a3_q[k]   <= a3_q[k-1];
          tnew_q[k] <= sat_dec(tnew_q[k-1]);
        end
        if (stall || !d_valid) begin
          a3_q[0]   <= '0;
          tnew_q[0] <= '0;
        end else begin
          a3_q[0]   <= d_a3;
          tnew_q[0] <= d_tnew;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed hazard sequences plus
// random traffic checked against an absolute-time producer model.
module tb_hazard_scoreboard;

  localparam int unsigned NSTAGE = 3;
  localparam int unsigned NRD    = 2;
  localparam int unsigned AW     = 5;
  localparam int unsigned TW     = 2;
  localparam int unsigned SW     = 2;
  localparam int unsigned CW     = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              d_valid;
  logic [AW-1:0]     d_a3;
  logic [TW-1:0]     d_tnew;
  logic [NRD*AW-1:0] d_rs;
  logic [NRD*TW-1:0] d_tuse;
  logic              d_mdu_use;
  logic              e_mdu_start;
  logic              mdu_busy;
  logic              flush;
  logic              stall;
  logic [NRD*SW-1:0] fwd_sel;
  logic [CW-1:0]     stall_cnt;

  hazard_scoreboard #(
    .NSTAGE (NSTAGE), .NRD (NRD), .AW (AW), .TW (TW), .SW (SW), .CW (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_a3        (d_a3),
    .d_tnew      (d_tnew),
    .d_rs        (d_rs),
    .d_tuse      (d_tuse),
    .d_mdu_use   (d_mdu_use),
    .e_mdu_start (e_mdu_start),
    .mdu_busy    (mdu_busy),
    .flush       (flush),
    .stall       (stall),
    .fwd_sel     (fwd_sel),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // A producer writes reg a3, enters E at cycle 'enter', result exists at 'ready'
  typedef struct {
    int a3;
    int enter;
    int ready;
  } prod_t;

  typedef struct {
    int stall;
    int sel0;
    int sel1;
    int cnt;
  } exp_t;

  prod_t inflight[$];
  exp_t  exp_q[$];
  int    cyc       = 0;
  int    model_cnt = 0;
  int    passed    = 0;
  int    total     = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
  endtask

  // Expected D-view result for one port from the in-flight producer list
  task automatic port_exp(input int rs, input int tu, output int sel, output int pst);
    int best;
    int rem;
    best = -1;
    sel  = 0;
    pst  = 0;
    if (rs != 0) begin
      foreach (inflight[j]) begin
        if (inflight[j].a3 == rs && (cyc - inflight[j].enter + 1) <= int'(NSTAGE)) begin
          if (best < 0 || inflight[j].enter > inflight[best].enter) best = j;
        end
      end
    end
    if (best >= 0) begin
      rem = inflight[best].ready - cyc;
      if (rem < 0) rem = 0;
      if (rem > tu) pst = 1;
      if (rem == 0) sel = cyc - inflight[best].enter + 1;
    end
  endtask

  task automatic step(input logic v, input int a3, input int tn,
                      input int rs0, input int tu0, input int rs1, input int tu1,
                      input logic mu, input logic es, input logic mb,
                      input logic fl, input logic rst);
    exp_t  e;
    int    s0, s1, p0, p1;
    prod_t p;
    @(negedge clk);
    d_valid     = v;
    d_a3        = AW'(a3);
    d_tnew      = TW'(tn);
    d_rs        = {AW'(rs1), AW'(rs0)};
    d_tuse      = {TW'(tu1), TW'(tu0)};
    d_mdu_use   = mu;
    e_mdu_start = es;
    mdu_busy    = mb;
    flush       = fl;
    reset       = rst;
    #1;
    port_exp(rs0, tu0, s0, p0);
    port_exp(rs1, tu1, s1, p1);
    e.stall = (v && (p0 != 0 || p1 != 0 || (mu && (mb || es)))) ? 1 : 0;
    e.sel0  = s0;
    e.sel1  = s1;
    e.cnt   = model_cnt;
    exp_q.push_back(e);
    if (!rst) begin
      inflight.delete();
      model_cnt = 0;
    end else begin
      if (e.stall != 0) model_cnt++;
      if (fl) inflight.delete();
      else if (e.stall == 0 && v && a3 != 0) begin
        p.a3    = a3;
        p.enter = cyc + 1;
        p.ready = cyc + 1 + tn;
        inflight.push_back(p);
      end
    end
    cyc++;
    while (inflight.size() > 0 && (cyc - inflight[0].enter + 1) > int'(NSTAGE))
      void'(inflight.pop_front());
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: compare every presented D-view against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", int'(stall), e.stall);
        chk("fwd_sel0", int'(fwd_sel[SW-1:0]), e.sel0);
        chk("fwd_sel1", int'(fwd_sel[2*SW-1:SW]), e.sel1);
        chk("stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    reset = 1'b0; d_valid = 1'b0; d_a3 = '0; d_tnew = '0; d_rs = '0; d_tuse = '0;
    d_mdu_use = 1'b0; e_mdu_start = 1'b0; mdu_busy = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    nop(3);

    // load-use: lw $8 (tnew 3) then addu reading $8 with tuse 1
    step(1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 9, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 8, 1, 8, 0, 0, 0, 0, 0, 1);
    nop(3);

    // ALU result into a branch
    step(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(3);

    // write-after-write: newest producer wins; rs=0 never matches
    step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 9, 3, 0, 0, 0, 0, 1);
    nop(3);

    // MDU interlock, then a non-MDU op under busy
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
    step(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    nop(3);

    // flush coincident with a stall
    step(1, 8, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1);
    nop(2);

    // reset mid-operation overrides flush and shifting
    step(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 4, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0, 1);
    nop(2);

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
    end

    nop(2);
    repeat (2) @(negedge clk);
    #5;
    chk("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
